// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, one-hot sequencer state
// encoding and the datapath strobe bundle.
//   OP_*     : 3-bit instruction-register opcode values
//   state_e  : 10-state one-hot sequencer encoding (IDLE, P0..P7, HALTED)
//   strobe_t : packed datapath strobes, MSB first:
//              inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [9:0] {
    S_IDLE   = 10'b00_0000_0001,
    S_P0     = 10'b00_0000_0010,
    S_P1     = 10'b00_0000_0100,
    S_P2     = 10'b00_0000_1000,
    S_P3     = 10'b00_0001_0000,
    S_P4     = 10'b00_0010_0000,
    S_P5     = 10'b00_0100_0000,
    S_P6     = 10'b00_1000_0000,
    S_P7     = 10'b01_0000_0000,
    S_HALTED = 10'b10_0000_0000
  } state_e;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
  } strobe_t;

  // Opcodes that read memory into the accumulator path.
  function automatic logic is_alu_ld(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/instr_seq_ctl_decode.sv
// iseq_decode: combinational strobe decoder for the instruction sequencer.
// Ports:
//   state   [9:0] : one-hot sequencer state (cpu_pkg::state_e encoding)
//   op      [2:0] : latched opcode (only meaningful in P3..P7)
//   zero          : accumulator-is-zero flag
//   strobes [6:0] : cpu_pkg::strobe_t bundle for that state
module iseq_decode
  import cpu_pkg::*;
(
  input  logic [9:0] state,
  input  logic [2:0] op,
  input  logic       zero,
  output logic [6:0] strobes
);

  strobe_t s;
  logic    alu_ld;

  always_comb begin
    s      = '0;
    alu_ld = is_alu_ld(op);
    case (state)
      S_P0: begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
      end
      S_P1: begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
        s.inc_pc  = 1'b1;
      end
      S_P3: s.inc_pc = 1'b1;
      S_P4: begin
        s.load_pc     = (op == OP_JMP);
        s.rd          = alu_ld;
        s.datactl_ena = (op == OP_STO);
      end
      S_P5: begin
        s.rd          = alu_ld;
        s.load_acc    = alu_ld;
        s.wr          = (op == OP_STO);
        s.datactl_ena = (op == OP_STO);
        s.load_pc     = (op == OP_JMP);
        s.inc_pc      = (op == OP_JMP) || ((op == OP_SKZ) && zero);
      end
      S_P6: begin
        s.rd          = alu_ld;
        s.datactl_ena = (op == OP_STO);
      end
      S_P7: s.inc_pc = (op == OP_SKZ) && zero;
      default: ;
    endcase
  end

  assign strobes = s;

endmodule

// File: rtl/instr_seq_ctl.sv
// instr_seq_ctl: eight-phase instruction sequencer for the simple CPU.
// Walks IDLE -> P0..P7 while ena is high, fetching in P0/P1 and executing
// the latched opcode in P3..P7; HLT parks the sequencer in HALTED until reset.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   ena         : fetch-window enable; low aborts the current instruction
//   opcode[2:0] : instruction-register opcode, latched on the edge into P3
//   zero        : accumulator-is-zero flag, sampled for SKZ in P5 and P7
//   inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena : registered strobes
//   halt        : sticky halted indication
//   retired[RETIRE_W-1:0] : retired-instruction count (ISEQ_RETIRE_CNT_EN only)
// Optional feature macro: ISEQ_RETIRE_CNT_EN enables the retired counter.
module instr_seq_ctl
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic [2:0]          opcode,
  input  logic                zero,
  output logic                inc_pc,
  output logic                load_pc,
  output logic                load_acc,
  output logic                load_ir,
  output logic                rd,
  output logic                wr,
  output logic                datactl_ena,
  output logic                halt
`ifdef ISEQ_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retired
`endif
);

  if (RETIRE_W < 1) begin : g_bad_retire_w
    $error("RETIRE_W must be at least 1");
  end

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [6:0] strb_q, strb_d;
  logic       halt_q;
  strobe_t    strb_v;

  // Next-state logic; ena low returns any active phase to IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (ena) state_d = S_P0;
      S_P0:   state_d = ena ? S_P1 : S_IDLE;
      S_P1:   state_d = ena ? S_P2 : S_IDLE;
      S_P2: begin
        if (ena) begin
          state_d = S_P3;
          op_d    = opcode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P3: begin
        if (!ena)                state_d = S_IDLE;
        else if (op_q == OP_HLT) state_d = S_HALTED;
        else                     state_d = S_P4;
      end
      S_P4:     state_d = ena ? S_P5 : S_IDLE;
      S_P5:     state_d = ena ? S_P6 : S_IDLE;
      S_P6:     state_d = ena ? S_P7 : S_IDLE;
      S_P7:     state_d = ena ? S_P0 : S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so the registered
  // outputs line up with the state occupied during the following cycle.
  iseq_decode u_decode (
    .state  (state_d),
    .op     (op_d),
    .zero   (zero),
    .strobes(strb_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_HLT;
      strb_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      strb_q  <= strb_d;
      halt_q  <= (state_d == S_HALTED);
    end
  end

  assign strb_v      = strb_q;
  assign inc_pc      = strb_v.inc_pc;
  assign load_pc     = strb_v.load_pc;
  assign load_acc    = strb_v.load_acc;
  assign load_ir     = strb_v.load_ir;
  assign rd          = strb_v.rd;
  assign wr          = strb_v.wr;
  assign datactl_ena = strb_v.datactl_ena;
  assign halt        = halt_q;

`ifdef ISEQ_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_q;
  logic                retire_evt;

  // An instruction retires when it leaves P7 (whatever ena does) or when
  // HLT commits to HALTED; an abort before P7 never counts.
  assign retire_evt = (state_q == S_P7) ||
                      ((state_q == S_P3) && (state_d == S_HALTED));

  always_ff @(posedge clk) begin
    if (reset)           retired_q <= '0;
    else if (retire_evt) retired_q <= retired_q + RETIRE_W'(1);
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_instr_seq_ctl.sv
module tb_instr_seq_ctl;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ena = 1'b0;
  logic [2:0]    opcode = 3'b000;
  logic          zero = 1'b0;
  logic          inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
  logic [RW-1:0] retired;

  instr_seq_ctl #(.RETIRE_W(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .opcode     (opcode),
    .zero       (zero),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .load_acc   (load_acc),
    .load_ir    (load_ir),
    .rd         (rd),
    .wr         (wr),
    .datactl_ena(datactl_ena),
    .halt       (halt)
`ifdef ISEQ_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

`ifndef ISEQ_RETIRE_CNT_EN
  assign retired = '0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase -1 = idle, 0..7 = P0..P7, 8 = halted.
  int         ph = -1;
  logic [2:0] mop = 3'b000;
  int         mret = 0;
  logic [6:0] mstrb = '0;

  function automatic logic [6:0] dut_vec();
    return {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};
  endfunction

  // Strobes required in phase p for opcode op, computed per output.
  function automatic logic [6:0] exp_strobes(input int p, input logic [2:0] op, input logic z);
    logic alu, mem, inc, lpc, lacc, lir, r, w, dc;
    alu  = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    mem  = (p >= 4) && (p <= 6);
    inc  = (p == 1) || (p == 3) || ((p == 5) && (op == 3'b111)) ||
           (((p == 5) || (p == 7)) && (op == 3'b001) && z);
    lpc  = (op == 3'b111) && ((p == 4) || (p == 5));
    lacc = (p == 5) && alu;
    lir  = (p == 0) || (p == 1);
    r    = (p == 0) || (p == 1) || (mem && alu);
    w    = (p == 5) && (op == 3'b110);
    dc   = mem && (op == 3'b110);
    return {inc, lpc, lacc, lir, r, w, dc};
  endfunction

  task automatic model_update(input logic rst, input logic en, input logic [2:0] opc, input logic z);
    if (rst) begin
      ph = -1; mop = 3'b000; mret = 0;
    end else if (ph == 8) begin
      ph = 8;
    end else if (ph == -1) begin
      if (en) ph = 0;
    end else if (!en) begin
      if (ph == 7) mret = mret + 1;
      ph = -1;
    end else begin
      if (ph == 2) mop = opc;
      if (ph == 3 && mop == 3'b000) begin
        ph = 8; mret = mret + 1;
      end else if (ph == 7) begin
        ph = 0; mret = mret + 1;
      end else begin
        ph = ph + 1;
      end
    end
    mstrb = exp_strobes(ph, mop, z);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("strobes", {25'd0, dut_vec()}, {25'd0, mstrb});
    chk("halt", {31'd0, halt}, {31'd0, (ph == 8)});
    chk("rd_wr_excl", {31'd0, rd & wr}, 32'd0);
`ifdef ISEQ_RETIRE_CNT_EN
    chk("retired", {{(32-RW){1'b0}}, retired}, 32'(mret % (1 << RW)));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update(reset, ena, opcode, zero);
    #1;
    compare();
  endtask

  task automatic run_instr(input string nm, input logic [2:0] op, input logic z,
                           input logic [6:0] t [8]);
    ena = 1'b1; opcode = op; zero = z;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("%s_P%0d", nm, k), {25'd0, dut_vec()}, {25'd0, t[k]});
    end
  endtask

  task automatic to_idle();
    ena = 1'b0;
    step();
  endtask

  // Literal per-phase expectations P0..P7 as {inc,lpc,lacc,lir,rd,wr,dctl}.
  logic [6:0] t_lda  [8] = '{7'b0001100, 7'b1001100, 7'b0000000, 7'b1000000,
                             7'b0000100, 7'b0010100, 7'b0000100, 7'b0000000};
  logic [6:0] t_sto  [8] = '{7'b0001100, 7'b1001100, 7'b0000000, 7'b1000000,
                             7'b0000001, 7'b0000011, 7'b0000001, 7'b0000000};
  logic [6:0] t_skz1 [8] = '{7'b0001100, 7'b1001100, 7'b0000000, 7'b1000000,
                             7'b0000000, 7'b1000000, 7'b0000000, 7'b1000000};
  logic [6:0] t_skz0 [8] = '{7'b0001100, 7'b1001100, 7'b0000000, 7'b1000000,
                             7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  logic [6:0] t_jmp  [8] = '{7'b0001100, 7'b1001100, 7'b0000000, 7'b1000000,
                             7'b0100000, 7'b1100000, 7'b0000000, 7'b0000000};

  initial begin
    logic [RW-1:0] ret_before;

    // Reset held for several cycles.
    reset = 1'b1; ena = 1'b1; opcode = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_strobes", {25'd0, dut_vec()}, 32'd0);
      chk("reset_halt", {31'd0, halt}, 32'd0);
    end
    reset = 1'b0;

    run_instr("LDA", 3'b101, 1'b0, t_lda);   to_idle();
    run_instr("STO", 3'b110, 1'b0, t_sto);   to_idle();
    run_instr("SKZ1", 3'b001, 1'b1, t_skz1); to_idle();
    run_instr("SKZ0", 3'b001, 1'b0, t_skz0); to_idle();
    run_instr("JMP", 3'b111, 1'b0, t_jmp);
    step();
    chk("jmp_next_P0", {25'd0, dut_vec()}, 32'b0001100);
    to_idle();

    // ADD aborted by ena dropping while in P5.
    ena = 1'b1; opcode = 3'b010;
    for (int i = 0; i < 6; i++) step();
    chk("add_P5", {25'd0, dut_vec()}, 32'b0010100);
    ret_before = retired;
    ena = 1'b0;
    step();
    chk("abort_strobes", {25'd0, dut_vec()}, 32'd0);
`ifdef ISEQ_RETIRE_CNT_EN
    chk("abort_retired", {{(32-RW){1'b0}}, retired}, {{(32-RW){1'b0}}, ret_before});
`endif
    ena = 1'b1;
    step();
    chk("restart_P0", {25'd0, dut_vec()}, 32'b0001100);
    to_idle();

    // HLT parks the sequencer regardless of ena/opcode.
    ena = 1'b1; opcode = 3'b000;
    for (int i = 0; i < 4; i++) step();
    chk("hlt_P3", {25'd0, dut_vec()}, 32'b1000000);
    chk("hlt_P3_halt", {31'd0, halt}, 32'd0);
    step();
    chk("halted_halt", {31'd0, halt}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      ena = 1'($urandom); opcode = 3'($urandom); zero = 1'($urandom);
      step();
      chk("halted_strobes", {25'd0, dut_vec()}, 32'd0);
      chk("halted_hold", {31'd0, halt}, 32'd1);
    end
    reset = 1'b1;
    step();
    chk("reset_from_halt", {31'd0, halt}, 32'd0);
    reset = 1'b0; ena = 1'b0;

`ifdef ISEQ_RETIRE_CNT_EN
    // 16 back-to-back LDAs wrap a 4-bit counter to zero.
    ena = 1'b1; opcode = 3'b101;
    for (int i = 0; i < 15 * 8 + 1; i++) step();
    chk("retired_15", {{(32-RW){1'b0}}, retired}, 32'd15);
    for (int i = 0; i < 8; i++) step();
    chk("retired_wrap", {{(32-RW){1'b0}}, retired}, 32'd0);
    to_idle();
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 79) == 0);
      ena    = ($urandom_range(0, 15) != 0);
      opcode = 3'($urandom);
      zero   = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctl.md
INSTR_SEQ_CTL -- requirements
Module: instr_seq_ctl

Interface
REQ-001 SHALL have parameter RETIRE_W, default 16, width of the retired-instruction counter; only used when ISEQ_RETIRE_CNT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ena, input, 1 bit: sequencer enable, driven by the clock generator's fetch window.
REQ-005 SHALL have port opcode, input, 3 bits: instruction-register opcode field.
REQ-006 SHALL have port zero, input, 1 bit: accumulator-is-zero flag.
REQ-007 SHALL have ports inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, each an output of 1 bit: datapath strobes.
REQ-008 SHALL have port halt, output, 1 bit: sticky halted indication.
REQ-009 SHALL have port retired, output, RETIRE_W bits: retired-instruction count, present only with ISEQ_RETIRE_CNT_EN.

Function
REQ-010 SHALL decode opcodes as HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-011 SHALL implement states IDLE, P0..P7, HALTED; transitions: IDLE->P0 when ena=1, Pn->Pn+1, P7->P0, any P-state->IDLE when ena=0.
REQ-012 SHALL register all strobes so that their values correspond to the state occupied in the same cycle; all strobes are 0 in IDLE and HALTED.
REQ-013 SHALL assert rd+load_ir in P0; rd+load_ir+inc_pc in P1; nothing in P2.
REQ-014 SHALL latch opcode into op_q on the edge entering P3; P3..P7 decode op_q only.
REQ-015 SHALL assert inc_pc in P3 for all opcodes; for HLT, SHALL enter HALTED at the P3->P4 edge instead of P4.
REQ-016 In P4: JMP -> load_pc; ADD/AND/XOR/LDA -> rd; STO -> datactl_ena; SKZ -> none.
REQ-017 In P5: ALU ops/LDA -> rd+load_acc; STO -> wr+datactl_ena; JMP -> load_pc+inc_pc; SKZ with zero=1 -> inc_pc.
REQ-018 In P6: ALU ops/LDA -> rd; STO -> datactl_ena. In P7: SKZ with zero=1 -> inc_pc; others none.
REQ-019 SHALL sample zero live in P5 and P7; zero changing between them is honoured independently per phase.
REQ-020 SHALL never assert rd and wr in the same cycle.
REQ-021 HALTED SHALL hold halt=1 and ignore ena and opcode until reset.
REQ-022 ena falling mid-instruction SHALL abort the instruction (no retirement), clear strobes next cycle, and restart at P0 on the next ena=1.

Reset
REQ-023 With reset=1 at a posedge, SHALL enter IDLE with all strobes 0, halt=0, op_q=000, retired=0; reset takes priority over ena and HALTED.
REQ-024 Reset held across multiple cycles SHALL keep all outputs at their reset values.

Configuration
REQ-025 With ISEQ_RETIRE_CNT_EN defined, SHALL increment retired by 1 on each P7->P0 or P7->IDLE edge and on HLT entry to HALTED, wrapping modulo 2^RETIRE_W.
REQ-026 Without ISEQ_RETIRE_CNT_EN, SHALL omit the retired port and counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL take opcode constants and the state encoding (one-hot, 10 states) from shared package cpu_pkg.
REQ-028 SHALL instantiate one sub-module, iseq_decode, a combinational op_q/state/zero -> strobe-vector decoder; the registers stay in instr_seq_ctl.

Verification
REQ-029 Reset sequence then ena=1, LDA (101): rd=1 in P0,P1,P4,P5,P6; load_acc=1 only in P5; inc_pc in P1,P3.
REQ-030 STO (110): datactl_ena=1 in P4..P6, wr=1 only in P5, rd never high in P3..P7.
REQ-031 SKZ with zero=1: inc_pc in P1,P3,P5,P7 (4 pulses); with zero=0: inc_pc in P1,P3 only.
REQ-032 JMP (111): load_pc in P4,P5; inc_pc in P5; next instruction P0 follows directly after P7.
REQ-033 HLT (000): halt=1 from the cycle after P3 onward and all strobes 0 for 20 cycles despite ena toggling; reset returns to IDLE with halt=0.
REQ-034 ena dropped in P5 of ADD: strobes 0 next cycle, state IDLE; with ISEQ_RETIRE_CNT_EN and RETIRE_W=4, retired is unchanged by the aborted ADD and 16 completed LDAs wrap it from 0 to 0.
